obc1_oam_arbiter: RTL and testbench

//  Shares the single-port OBC1 OAM low RAM (1024x8) between the SNES-side OBC1 access path and an
//  MCU-side debug/savestate port. The SNES path owns the RAM whenever its chip select is active and
//  is never delayed. MCU reads and writes are queued and issued only in guarded idle gaps.
//  The block sits between the OBC1 register/decode logic and the RAM primitive.

---
 rtl/obc1_oam_arbiter.sv | 173 +++++++++++++++++
 tb/tb_obc1_oam_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/obc1_oam_arbiter.sv
// OBC1 OAM low RAM arbiter: SNES path owns the single-port RAM whenever its
// chip select is up; MCU debug/savestate accesses are latched and slipped
// into idle gaps that have lasted at least GUARD cycles.
module obc1_oam_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int RAM_LAT = 1,
    parameter int GUARD   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              snes_cs,
    input  logic              snes_we,
    input  logic [ADDR_W-1:0] snes_addr,
    input  logic [DATA_W-1:0] snes_din,
    output logic [DATA_W-1:0] snes_dout,
    input  logic              mcu_req,
    input  logic              mcu_we,
    input  logic [ADDR_W-1:0] mcu_addr,
    input  logic [DATA_W-1:0] mcu_din,
    output logic              mcu_busy,
    output logic              mcu_ack,
    output logic [DATA_W-1:0] mcu_dout,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [3:0] GUARD_V = 4'(GUARD);

    typedef enum logic [1:0] {IDLE, WAIT, ISSUE, RDWAIT} state_e;

    state_e              state_q, state_d;
    logic                req_we_q, req_we_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic [DATA_W-1:0]   req_din_q, req_din_d;
    logic                busy_q, busy_d;
    logic                ack_q, ack_d;
    logic [DATA_W-1:0]   mcu_dout_q, mcu_dout_d;
    logic [DATA_W-1:0]   snes_dout_q, snes_dout_d;
    logic [3:0]          guard_q, guard_d;
    logic [RAM_LAT-1:0]  mcu_tag_q, mcu_tag_d;
    logic [RAM_LAT-1:0]  snes_tag_q, snes_tag_d;

    logic gap_ok;
    logic mcu_issue;

    assign gap_ok    = (guard_q == 4'd0) && !snes_cs;
    // An MCU slot is only real when SNES did not grab the RAM in that cycle.
    assign mcu_issue = (state_q == ISSUE) && !snes_cs;

    // RAM port mux; SNES always has priority, outputs forced low during reset.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = snes_addr;
        ram_din  = snes_din;
        if (!rst_n) begin
            ram_addr = '0;
            ram_din  = '0;
        end else if (snes_cs) begin
            ram_we = snes_we;
        end else if (state_q == ISSUE) begin
            ram_we   = req_we_q;
            ram_addr = req_addr_q;
            ram_din  = req_din_q;
        end
    end

    // Guard counter: reload while SNES is active, count down through idle gap.
    always_comb begin
        guard_d = guard_q;
        if (snes_cs)
            guard_d = GUARD_V;
        else if (guard_q != 4'd0)
            guard_d = guard_q - 4'd1;
    end

    // Read-slot tags shift every cycle regardless of snes_cs so in-flight
    // reads always land in the right output register.
    always_comb begin
        mcu_tag_d     = '0;
        snes_tag_d    = '0;
        mcu_tag_d[0]  = mcu_issue && !req_we_q;
        snes_tag_d[0] = snes_cs && !snes_we;
        for (int i = 1; i < RAM_LAT; i++) begin
            mcu_tag_d[i]  = mcu_tag_q[i-1];
            snes_tag_d[i] = snes_tag_q[i-1];
        end
        snes_dout_d = snes_tag_q[RAM_LAT-1] ? ram_dout : snes_dout_q;
        mcu_dout_d  = mcu_tag_q[RAM_LAT-1]  ? ram_dout : mcu_dout_q;
    end

    // MCU request FSM: next state, request latch, busy/ack.
    always_comb begin
        state_d    = state_q;
        req_we_d   = req_we_q;
        req_addr_d = req_addr_q;
        req_din_d  = req_din_q;
        busy_d     = busy_q;
        ack_d      = 1'b0;
        case (state_q)
            IDLE: begin
                // A request coinciding with the ack cycle is dropped.
                if (mcu_req && !ack_q) begin
                    req_we_d   = mcu_we;
                    req_addr_d = mcu_addr;
                    req_din_d  = mcu_din;
                    busy_d     = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (gap_ok)
                    state_d = ISSUE;
            end
            ISSUE: begin
                if (snes_cs) begin
                    state_d = WAIT;
                end else if (req_we_q) begin
                    ack_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = RDWAIT;
                end
            end
            RDWAIT: begin
                if (mcu_tag_q[RAM_LAT-1]) begin
                    ack_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_din_q   <= '0;
            busy_q      <= 1'b0;
            ack_q       <= 1'b0;
            mcu_dout_q  <= '0;
            snes_dout_q <= '0;
            guard_q     <= GUARD_V;
            mcu_tag_q   <= '0;
            snes_tag_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_din_q   <= req_din_d;
            busy_q      <= busy_d;
            ack_q       <= ack_d;
            mcu_dout_q  <= mcu_dout_d;
            snes_dout_q <= snes_dout_d;
            guard_q     <= guard_d;
            mcu_tag_q   <= mcu_tag_d;
            snes_tag_q  <= snes_tag_d;
        end
    end

    assign snes_dout = snes_dout_q;
    assign mcu_dout  = mcu_dout_q;
    assign mcu_busy  = busy_q;
    assign mcu_ack   = ack_q;

endmodule

// File: tb/tb_obc1_oam_arbiter.sv
// Bench for obc1_oam_arbiter: behavioural RAM with RAM_LAT read latency,
// scoreboard of accepted MCU requests checked when each ack appears.
module tb_obc1_oam_arbiter;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 8;
    localparam int RAM_LAT = 2;
    localparam int GUARD   = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              snes_cs = 1'b0, snes_we = 1'b0;
    logic [ADDR_W-1:0] snes_addr = '0;
    logic [DATA_W-1:0] snes_din = '0;
    logic [DATA_W-1:0] snes_dout;
    logic              mcu_req = 1'b0, mcu_we = 1'b0;
    logic [ADDR_W-1:0] mcu_addr = '0;
    logic [DATA_W-1:0] mcu_din = '0;
    logic              mcu_busy, mcu_ack;
    logic [DATA_W-1:0] mcu_dout;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    obc1_oam_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(RAM_LAT), .GUARD(GUARD)) dut (
        .clk(clk), .rst_n(rst_n),
        .snes_cs(snes_cs), .snes_we(snes_we), .snes_addr(snes_addr), .snes_din(snes_din),
        .snes_dout(snes_dout),
        .mcu_req(mcu_req), .mcu_we(mcu_we), .mcu_addr(mcu_addr), .mcu_din(mcu_din),
        .mcu_busy(mcu_busy), .mcu_ack(mcu_ack), .mcu_dout(mcu_dout),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // behavioural RAM
    logic [DATA_W-1:0] mem [1024];
    logic [DATA_W-1:0] rdp [RAM_LAT];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < RAM_LAT; i++) rdp[i] = '0;
    end
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        rdp[0] <= mem[ram_addr];
        for (int i = 1; i < RAM_LAT; i++) rdp[i] <= rdp[i-1];
    end
    assign ram_dout = rdp[RAM_LAT-1];

    int n_chk = 0, n_fail = 0;
    int cyc = 0, n_we = 0, n_ack = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                rcyc;
        int                lat;   // 0 = latency not checked (contended)
    } sb_t;
    sb_t sbq[$];
    sb_t e;

    // scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_we) n_we++;
            if (mcu_ack) begin
                n_ack++;
                chk("busy_at_ack", mcu_busy, 0);
                if (sbq.size() == 0) begin
                    chk("spurious_ack", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    if (e.lat != 0) chk("ack_lat", cyc - e.rcyc, e.lat);
                    if (!e.we) chk("rd_data", mcu_dout, e.data);
                end
            end
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while ((mcu_busy || mcu_ack) && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 300) chk("idle_timeout", 0, 1);
    endtask

    // one-cycle request pulse; returns in the cycle after sampling (state WAIT)
    task automatic drive_req(input logic we, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d, input int lat);
        sb_t s;
        @(posedge clk); #1;
        mcu_req = 1'b1; mcu_we = we; mcu_addr = a; mcu_din = d;
        s.we = we; s.addr = a; s.data = d; s.rcyc = cyc + 1; s.lat = lat;
        sbq.push_back(s);
        @(posedge clk); #1;
        mcu_req = 1'b0;
    endtask

    task automatic mcu_op(input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input int lat);
        wait_idle();
        drive_req(we, a, d, lat);
        wait_idle();
    endtask

    task automatic snes_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(posedge clk); #1;
        snes_cs = 1'b1; snes_we = 1'b1; snes_addr = a; snes_din = d;
        @(posedge clk); #1;
        snes_cs = 1'b0; snes_we = 1'b0;
    endtask

    initial begin
        int w0, bad, kiss, k;
        logic [DATA_W-1:0] old_sd;

        // reset state
        #12;
        chk("reset_outs", {snes_dout, mcu_busy, mcu_ack, mcu_dout, ram_we, ram_addr, ram_din}, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (GUARD + 2) @(posedge clk);
        #1;
        chk("post_reset_busy", {mcu_busy, mcu_ack}, 0);

        // 1: idle bus write then read
        w0 = n_we;
        mcu_op(1'b1, 10'h3A5, 8'h5C, 2);
        chk("wr_we_pulses", n_we - w0, 1);
        chk("wr_mem", mem[10'h3A5], 8'h5C);
        w0 = n_we;
        mcu_op(1'b0, 10'h3A5, 8'h5C, 2 + RAM_LAT);
        chk("rd_no_we", n_we - w0, 0);

        snes_write(10'h010, 8'h66);

        // 2: long SNES burst holds off a pending MCU read
        @(posedge clk); #1;
        snes_cs = 1'b1; snes_we = 1'b0; snes_addr = 10'h200;
        drive_req(1'b0, 10'h3A5, 8'h5C, 0);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (ram_addr !== 10'h200 || ram_we !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        chk("cs_hold_no_issue", bad, 0);
        snes_cs = 1'b0; snes_addr = 10'h000;
        // gap_ok appears once the reloaded count has run down; issue follows it
        kiss = -1;
        for (int i = 0; i < 20; i++) begin
            if (kiss < 0 && ram_addr === 10'h3A5) kiss = i;
            @(posedge clk); #1;
        end
        chk("guard_gap", kiss, GUARD + 1);
        wait_idle();

        // 3: SNES write collides with the MCU write slot
        drive_req(1'b1, 10'h2C4, 8'h39, 0);
        @(posedge clk); #1;  // ISSUE cycle
        snes_cs = 1'b1; snes_we = 1'b1; snes_addr = 10'h123; snes_din = 8'hA7;
        #1;
        chk("snes_wins_mux", {ram_we, ram_addr, ram_din}, {1'b1, 10'h123, 8'hA7});
        @(posedge clk); #1;
        snes_cs = 1'b0; snes_we = 1'b0;
        chk("void_slot_busy", mcu_busy, 1);
        wait_idle();
        mcu_op(1'b0, 10'h123, 8'hA7, 2 + RAM_LAT);
        mcu_op(1'b0, 10'h2C4, 8'h39, 2 + RAM_LAT);

        // 4: MCU read in flight when an SNES read starts
        old_sd = snes_dout;
        drive_req(1'b0, 10'h3A5, 8'h5C, 2 + RAM_LAT);
        @(posedge clk); #1;  // ISSUE
        @(posedge clk); #1;
        snes_cs = 1'b1; snes_we = 1'b0; snes_addr = 10'h010;
        @(posedge clk); #1;
        snes_cs = 1'b0;
        repeat (RAM_LAT - 1) @(posedge clk);
        #1;
        chk("snes_no_cross", snes_dout, old_sd);
        wait_idle();
        repeat (RAM_LAT + 2) @(posedge clk);
        #1;
        chk("snes_rd_data", snes_dout, 8'h66);
        chk("mcu_dout_held", mcu_dout, 8'h5C);

        // 5: reset while waiting
        @(posedge clk); #1;
        snes_cs = 1'b1; snes_we = 1'b0; snes_addr = 10'h155;
        drive_req(1'b1, 10'h077, 8'hC3, 0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", {snes_dout, mcu_busy, mcu_ack, mcu_dout, ram_we, ram_addr, ram_din}, 0);
        sbq.delete();
        @(posedge clk); #2;
        snes_cs = 1'b0;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("no_ack_after_reset", mcu_busy, 0);
        mcu_op(1'b1, 10'h078, 8'h4D, 2);
        mcu_op(1'b0, 10'h078, 8'h4D, 2 + RAM_LAT);

        // 6: requests while busy and in the ack cycle are ignored
        w0 = n_ack;
        drive_req(1'b1, 10'h055, 8'h11, 0);
        mcu_req = 1'b1; mcu_we = 1'b1; mcu_addr = 10'h066; mcu_din = 8'hEE;
        k = 0;
        while (!mcu_ack && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("busy_ack_seen", mcu_ack, 1);
        @(posedge clk); #1;
        mcu_req = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("one_ack", n_ack - w0, 1);
        chk("ignored_busy", mcu_busy, 0);
        mcu_op(1'b0, 10'h066, 8'h00, 2 + RAM_LAT);
        mcu_op(1'b0, 10'h055, 8'h11, 2 + RAM_LAT);

        repeat (5) @(posedge clk);
        chk("sb_drain", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
